// File: rtl/display_scan_mux_if.sv
// Value/control bus for display_scan_mux.
// The master drives value, dp and enable; the slave returns the digit and anode lines.
interface display_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    value_valid;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    enable;
  logic [3:0]              digit_data;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp_out;
  logic                    frame_done;

  modport master (
    output value_in, value_valid, dp_in, enable,
    input  digit_data, an, dp_out, frame_done
  );

  modport slave (
    input  value_in, value_valid, dp_in, enable,
    output digit_data, an, dp_out, frame_done
  );
endinterface

// File: rtl/display_scan_mux.sv
// Scans a packed multi-digit value onto a common-anode display, one digit per slot.
// Ports: clk, reset (sync, active-high), bus (slave): value_in/value_valid/dp_in/enable
// in; digit_data/an/dp_out/frame_done out. an lags digit_data by one clock.
module display_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_BLANK     = 1
) (
  input logic               clk,
  input logic               reset,
  display_scan_mux_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [VW-1:0]         r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [3:0]            r_digit;
  logic [IW-1:0]         r_s1_idx;
  logic                  r_s1_lit;
  logic                  r_s1_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_dp_out;
  logic                  r_frame_done;

  logic                  w_slot_end;
  logic                  w_bound;
  logic [3:0]            w_nib;
  logic                  w_zero;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_lit;

  assign w_slot_end = bus.enable && (r_cnt == LAST_CNT);
  assign w_bound    = w_slot_end && (r_idx == LAST_IDX);
  assign w_nib      = r_disp_val[{r_idx, 2'b00} +: 4];

  // Walk from the most significant digit down; a digit blanks while
  // everything at and above it is zero, unless its dp is requested.
  always_comb begin
    w_zero  = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero     = w_zero & (r_disp_val[4*i +: 4] == 4'h0);
      w_blank[i] = (LZ_BLANK != 0) && (i != 0) && w_zero && !r_disp_dp[i];
    end
  end

  assign w_lit = bus.enable && (r_cnt >= BLANK_C) && !w_blank[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (bus.enable) begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Pending catches every strobe; display only changes on a frame
  // boundary, taking a same-cycle strobe directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else begin
      if (bus.value_valid) begin
        r_pend_val <= bus.value_in;
        r_pend_dp  <= bus.dp_in;
      end
      if (w_bound) begin
        r_disp_val <= bus.value_valid ? bus.value_in : r_pend_val;
        r_disp_dp  <= bus.value_valid ? bus.dp_in : r_pend_dp;
      end
    end
  end

  // Stage 1 feeds the decoder; stage 2 drives anodes a clock later
  // so they meet the decoder's registered segment output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit      <= 4'h0;
      r_s1_idx     <= '0;
      r_s1_lit     <= 1'b0;
      r_s1_dp      <= 1'b0;
      r_an         <= '1;
      r_dp_out     <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_digit      <= w_nib;
      r_s1_idx     <= r_idx;
      r_s1_lit     <= w_lit;
      r_s1_dp      <= r_disp_dp[r_idx];
      r_an         <= r_s1_lit ? ~(NUM_DIGITS'(1) << r_s1_idx) : '1;
      r_dp_out     <= r_s1_lit ? ~r_s1_dp : 1'b1;
      r_frame_done <= w_bound;
    end
  end

  assign bus.digit_data = r_digit;
  assign bus.an         = r_an;
  assign bus.dp_out     = r_dp_out;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux at 4 digits, 8-cycle slots, 2-cycle blank.
// Frames are checked edge by edge against hand-written digit/anode tables.
module tb_display_scan_mux;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  display_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  display_scan_mux #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2),
    .LZ_BLANK(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] d);
    bus.value_in    = v;
    bus.dp_in       = d;
    bus.value_valid = 1'b1;
    tick();
    bus.value_valid = 1'b0;
  endtask

  task automatic wait_frame;
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("frame_wait", {31'd0, bus.frame_done}, 32'd1);
  endtask

  // Starts on the edge that showed frame_done; ends on the next one.
  // dd: digit per slot, an_lit: anodes when slot lit (F = blanked),
  // dp_lo: dp_out per slot when lit.
  task automatic scan_frame(input string tag, input logic [15:0] dd,
                            input logic [15:0] an_lit,
                            input logic [3:0] dp_lo);
    int s1, s2, c2;
    logic [3:0] ea;
    logic       ed;
    for (int k = 1; k <= 32; k++) begin
      tick();
      s1 = (k - 1) / 8;
      check({tag, "_dd"}, {28'd0, bus.digit_data}, {28'd0, dd[4*s1 +: 4]});
      if (k >= 2) begin
        s2 = (k - 2) / 8;
        c2 = (k - 2) % 8;
        ea = (c2 >= 2) ? an_lit[4*s2 +: 4] : 4'hF;
        ed = (c2 >= 2) ? dp_lo[s2] : 1'b1;
        check({tag, "_an"}, {28'd0, bus.an}, {28'd0, ea});
        check({tag, "_dp"}, {31'd0, bus.dp_out}, {31'd0, ed});
      end
      check({tag, "_fd"}, {31'd0, bus.frame_done}, {31'd0, (k == 32)});
    end
  endtask

  initial begin
    logic [3:0] ea;
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.value_valid = 1'b0;
    bus.value_in    = 16'h0;
    bus.dp_in       = 4'h0;
    repeat (3) tick();
    check("rst_dd", {28'd0, bus.digit_data}, 32'h0);
    check("rst_an", {28'd0, bus.an}, 32'hF);
    check("rst_dp", {31'd0, bus.dp_out}, 32'd1);
    check("rst_fd", {31'd0, bus.frame_done}, 32'd0);

    reset      = 1'b0;
    bus.enable = 1'b1;
    strobe(16'h1234, 4'h0);
    wait_frame();

    fork
      scan_frame("f1234", 16'h1234, 16'h7BDE, 4'hF);
      begin
        repeat (10) tick();
        strobe(16'hAAAA, 4'h0);
        tick();
        strobe(16'hBBBB, 4'h0);
      end
    join

    fork
      scan_frame("fBBBB", 16'hBBBB, 16'h7BDE, 4'hF);
      begin
        repeat (5) tick();
        strobe(16'h0050, 4'h0);
      end
    join

    fork
      scan_frame("lz", 16'h0050, 16'hFFDE, 4'hF);
      begin
        repeat (7) tick();
        strobe(16'h0050, 4'b0100);
      end
    join

    fork
      scan_frame("lzdp", 16'h0050, 16'hFBDE, 4'b1011);
      begin
        repeat (31) tick();
        strobe(16'h7777, 4'h0);
      end
    join

    scan_frame("bypass", 16'h7777, 16'h7BDE, 4'hF);

    repeat (19) tick();
    bus.enable = 1'b0;
    for (int t = 20; t <= 52; t++) begin
      tick();
      if (t == 20)      ea = 4'hB;
      else if (t <= 40) ea = 4'hF;
      else if (t <= 45) ea = 4'hB;
      else if (t <= 47) ea = 4'hF;
      else              ea = 4'h7;
      check("hold_dd", {28'd0, bus.digit_data}, 32'h7);
      check("hold_an", {28'd0, bus.an}, {28'd0, ea});
      check("hold_dp", {31'd0, bus.dp_out}, 32'd1);
      check("hold_fd", {31'd0, bus.frame_done}, {31'd0, (t == 52)});
      if (t == 39) bus.enable = 1'b1;
    end

    strobe(16'hFFFF, 4'h0);
    wait_frame();
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("mrst_dd", {28'd0, bus.digit_data}, 32'h0);
    check("mrst_an", {28'd0, bus.an}, 32'hF);
    check("mrst_dp", {31'd0, bus.dp_out}, 32'd1);
    check("mrst_fd", {31'd0, bus.frame_done}, 32'd0);
    reset = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      tick();
      ea = (r <= 3) ? 4'hF : 4'hE;
      check("post_dd", {28'd0, bus.digit_data}, 32'h0);
      check("post_an", {28'd0, bus.an}, {28'd0, ea});
      check("post_dp", {31'd0, bus.dp_out}, 32'd1);
      check("post_fd", {31'd0, bus.frame_done}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Upstream feeder for the registered hex-to-seven-segment decoder on a multi-digit common-anode display.
- Takes a packed multi-nibble count value and time-multiplexes it one digit at a time.
- Drives the decoder's 4-bit nibble input and the active-low anode and decimal-point lines, delayed so they line up with the decoder's one-clock output latency.
- Provides tear-free value updates, anti-ghosting dead time and leading-zero blanking.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; digit 0 is least significant (rightmost).
- REFRESH_DIV, 100000: clk cycles per digit slot; must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off (anti-ghosting).
- LZ_BLANK, 1: 1 enables leading-zero blanking; 0 always lights every digit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- value_in  in  4*NUM_DIGITS  packed nibbles; nibble i = value_in[4i+3:4i]
- value_valid  in  1  one-cycle strobe; captures value_in
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit; sampled with value_in
- enable  in  1  1 = scan running; 0 = hold scan position with display dark
- digit_data  out  4  nibble to the decoder's 4-bit input (registered)
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all ones (registered)
- dp_out  out  1  decimal point, active-low (registered)
- frame_done  out  1  one-cycle pulse when the last digit slot completes

Behaviour:
- Reset (clk, reset, synchronous, active-high). Takes priority over everything and applies mid-scan:
  - prescale counter = 0, digit index = 0
  - pending and display registers = 0, dp registers = 0
  - digit_data = 0, an = all ones, dp_out = 1, frame_done = 0
- Prescaler: cnt counts 0..REFRESH_DIV-1 while enable = 1.
  - At cnt = REFRESH_DIV-1: cnt wraps to 0 and the index advances (NUM_DIGITS-1 wraps to 0).
  - The cycle where the index wraps from NUM_DIGITS-1 is the frame boundary.
- Double buffering:
  - value_valid loads value_in and dp_in into the pending registers; the last strobe before the boundary wins.
  - The pending registers copy into the display registers on the frame boundary only, so the display never tears mid-frame.
  - value_valid on the boundary cycle: value_in bypasses pending and loads display directly, and pending is also updated.
- Leading-zero blanking (LZ_BLANK = 1):
  - Digit i > 0 is blanked when display nibble i and every more significant nibble are 0.
  - Digit 0 is never blanked.
  - A digit with its dp bit set is never blanked.
- Pipeline, aligned with the decoder's one-clock latency:
  - Stage 1: digit_data <= display nibble[index], every cycle.
  - Stage 2: an and dp_out are registered one clock after digit_data, derived from the index and cnt of the previous cycle.
  - Result: an lags digit_data by exactly one clock.
- Anode rule, for the stage-1 snapshot:
  - an bit index = 0 iff enable = 1, cnt >= BLANK_CYCLES, and the digit is not blanked.
  - All other an bits = 1.
  - dp_out = ~dp[index] when that anode is lit, else 1.
- frame_done: pulses one cycle on the boundary cycle (registered, so visible the next clock); 0 when enable = 0.
- enable = 0:
  - cnt and index freeze.
  - an goes all ones one clock after digit_data would, and dp_out = 1.
  - Pending and display loads still operate at a boundary; no boundary can occur while frozen.
- enable rising: scanning resumes from the frozen cnt and index; no extra dead time is inserted.
- Widths: index is clog2(NUM_DIGITS) bits (minimum 1); cnt is clog2(REFRESH_DIV) bits. There are no arithmetic overflow paths other than the defined wraps.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1):
- Reset, then enable=1, value_in=16'h1234 strobe: after the first boundary, digit_data cycles 4,3,2,1, 8 cycles each. Per slot, an is 1111 for 2 cycles, then 1110/1101/1011/0111. an lags digit_data by 1 clock. frame_done pulses every 32 cycles.
- value_in=16'h0050, dp_in=0: an never lights digits 3 and 2; digits 1 and 0 light, with digit_data 5 and 0. With dp_in=4'b0100, digit 2 lights, digit_data=0 and dp_out=0.
- value_in=16'hAAAA strobe mid-frame, then 16'hBBBB strobe two cycles later: the current frame keeps its old digits. The next frame shows B on all digits and A never appears.
- value_valid with 16'h7777 on the exact boundary cycle: the frame starting that cycle shows 7 on digit 0.
- enable dropped mid-slot 2 for 20 cycles: an=1111, dp_out=1, frame_done=0. On re-enable the slot resumes at the same cnt and index, and the remaining slot length is correct.
- reset asserted mid-frame with value 16'hFFFF: next clock an=1111, digit_data=0, dp_out=1. After release the scan restarts at digit 0 showing 0.
